// File: rtl/spi_master_writer.sv
// SPI master for the CPLD register-file slave.
// Each transaction drops CS, sends one address byte and then len data bytes, MSB first.
// Data bytes are pulled from a valid/ready stream. Each data slot also captures the
// slave's returned byte.
// SCL idles low. MOSI changes while SCL is low, and the slave samples on the SCL rise.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | waiting for start_i, CS high
// ST_CS_SETUP  | CS low, SCL low, setup time before the first edge
// ST_SHIFT     | shifting one byte; high_q selects the SCL low/high half-period
// ST_GAP       | SCL low between bytes so the slave can re-arm its receiver
// ST_FETCH     | tx_ready_o high, stalling until the next data byte arrives
// ST_CS_HOLD   | SCL low after the last edge, before CS is released
// ST_CS_IDLE   | CS high for the minimum deselect time, then done_o
module spi_master_writer #(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [7:0]       addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cs_o,
  output logic             scl_o,
  output logic             mosi_o,
  input  logic             miso_i
);

  localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_TC = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_FETCH,
    ST_CS_HOLD,
    ST_CS_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             high_q, high_d;
  logic             data_slot_q, data_slot_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             cs_q, cs_d;
  logic             scl_q, scl_d;
  logic             mosi_q, mosi_d;
  logic             tx_ready_q, tx_ready_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_zero;

  // Next-state and registered-output logic; the shared timer counts down to terminal zero
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    high_d      = high_q;
    data_slot_d = data_slot_q;
    rem_d       = rem_q;
    sh_d        = sh_q;
    rx_sh_d     = rx_sh_q;
    cs_d        = cs_q;
    scl_d       = scl_q;
    mosi_d      = mosi_q;
    tx_ready_d  = tx_ready_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_zero    = (cnt_q == '0);
    if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sh_d        = addr_i;
          rem_d       = len_i;
          data_slot_d = 1'b0;
          cs_d        = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = DIV_TC;
          state_d     = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_zero) begin
          mosi_d  = sh_q[7];
          bit_d   = 3'd7;
          high_d  = 1'b0;
          cnt_d   = DIV_TC;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_zero) begin
          cnt_d = DIV_TC;
          if (!high_q) begin
            // miso is captured on the same edge that raises SCL
            scl_d   = 1'b1;
            high_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], miso_i};
          end else begin
            scl_d  = 1'b0;
            high_d = 1'b0;
            if (bit_q != 3'd0) begin
              bit_d  = bit_q - 3'd1;
              sh_d   = {sh_q[6:0], 1'b0};
              mosi_d = sh_q[6];
            end else begin
              if (data_slot_q) begin
                rx_data_d  = rx_sh_q;
                rx_valid_d = 1'b1;
              end
              if (rem_q == '0) begin
                state_d = ST_CS_HOLD;
              end else begin
                cnt_d   = GAP_TC;
                state_d = ST_GAP;
              end
            end
          end
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          tx_ready_d = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (tx_valid_i && tx_ready_q) begin
          sh_d        = tx_data_i;
          mosi_d      = tx_data_i[7];
          rem_d       = rem_q - LEN_W'(1);
          tx_ready_d  = 1'b0;
          data_slot_d = 1'b1;
          bit_d       = 3'd7;
          high_d      = 1'b0;
          cnt_d       = DIV_TC;
          state_d     = ST_SHIFT;
        end
      end
      ST_CS_HOLD: begin
        if (cnt_zero) begin
          cs_d    = 1'b1;
          cnt_d   = DIV_TC;
          state_d = ST_CS_IDLE;
        end
      end
      ST_CS_IDLE: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      high_q      <= 1'b0;
      data_slot_q <= 1'b0;
      rem_q       <= '0;
      sh_q        <= 8'h00;
      rx_sh_q     <= 8'h00;
      cs_q        <= 1'b1;
      scl_q       <= 1'b0;
      mosi_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      high_q      <= high_d;
      data_slot_q <= data_slot_d;
      rem_q       <= rem_d;
      sh_q        <= sh_d;
      rx_sh_q     <= rx_sh_d;
      cs_q        <= cs_d;
      scl_q       <= scl_d;
      mosi_q      <= mosi_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cs_o       = cs_q;
  assign scl_o      = scl_q;
  assign mosi_o     = mosi_q;
  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_spi_master_writer.sv
// Bench for spi_master_writer: slave-side model plus directed transactions.
module tb_spi_master_writer;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 4;
  localparam int LEN_W   = 4;

  logic             clk_i = 1'b0;
  logic             reset_n_i = 1'b0;
  logic             start_i = 1'b0;
  logic [7:0]       addr_i = 8'h00;
  logic [LEN_W-1:0] len_i = '0;
  logic [7:0]       tx_data_i = 8'h00;
  logic             tx_valid_i = 1'b0;
  logic             tx_ready_o;
  logic [7:0]       rx_data_o;
  logic             rx_valid_o;
  logic             busy_o;
  logic             done_o;
  logic             cs_o;
  logic             scl_o;
  logic             mosi_o;
  logic             miso_i = 1'b0;

  spi_master_writer #(.CLK_DIV(CLK_DIV), .GAP(GAP), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .addr_i(addr_i),
    .len_i(len_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .busy_o(busy_o), .done_o(done_o), .cs_o(cs_o), .scl_o(scl_o),
    .mosi_o(mosi_o), .miso_i(miso_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // model state: expected serial bits and returned bytes for the current transaction
  logic       exp_bits[$];
  logic [7:0] exp_rx[$];
  logic [7:0] miso_pat = 8'h96;

  // per-transaction observation counters
  int rise_cnt = 0, fall_cnt = 0, rx_cnt = 0, ready_cnt = 0, busy_cnt = 0, done_cnt = 0;
  int cs_high_run = 0;
  bit mon_en = 1'b0;
  bit seen_cs_low = 1'b0;
  logic prev_scl = 1'b0, prev_cs = 1'b1;
  logic [7:0] last_rx = 8'h00;

  // slave register-file model
  int         slave_bits = 0;
  logic [7:0] slave_sh = 8'h00, slave_addr = 8'h00;
  logic [7:0] slave_mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(b[7]);
      b = b << 1;
    end
  endtask

  task automatic prep(input logic [7:0] addr, input int len, input logic [7:0] b0,
                      input logic [7:0] b1);
    rise_cnt = 0; rx_cnt = 0; ready_cnt = 0; busy_cnt = 0; done_cnt = 0;
    exp_bits.delete();
    exp_rx.delete();
    push_byte(addr);
    if (len >= 1) begin push_byte(b0); exp_rx.push_back(miso_pat); end
    if (len >= 2) begin push_byte(b1); exp_rx.push_back(miso_pat); end
  endtask

  task automatic begin_txn(input logic [7:0] addr, input int len, input logic [7:0] b0,
                           input logic [7:0] b1);
    int n = 0;
    while (busy_o !== 1'b0 && n < 2000) begin step(); n++; end
    prep(addr, len, b0, b1);
    addr_i  = addr;
    len_i   = LEN_W'(len);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_accepted", 32'(busy_o), 1);
    chk("cs_low_after_start", 32'(cs_o), 0);
  endtask

  task automatic feed_byte(input logic [7:0] data, input int stall);
    int n = 0;
    int bad = 0;
    int r0;
    while (tx_ready_o !== 1'b1 && n < 2000) begin step(); n++; end
    chk("tx_ready_seen", 32'(tx_ready_o), 1);
    if (stall > 0) begin
      r0 = rise_cnt;
      for (int i = 0; i < stall; i++) begin
        step();
        if (scl_o !== 1'b0 || cs_o !== 1'b0 || tx_ready_o !== 1'b1) bad++;
      end
      chk("stall_quiet", bad, 0);
      chk("stall_no_edges", rise_cnt, r0);
    end
    tx_valid_i = 1'b1;
    tx_data_i  = data;
    step();
    tx_valid_i = 1'b0;
    tx_data_i  = 8'hFF;
    chk("tx_ready_drop", 32'(tx_ready_o), 0);
  endtask

  // Waits for done_o and checks the whole transaction; optionally starts the next one
  // in the cycle right after done_o.
  task automatic end_txn(input int len, input bit chain, input logic [7:0] caddr);
    int n = 0;
    while (done_o !== 1'b1 && n < 3000) begin step(); n++; end
    chk("done_seen", 32'(done_o), 1);
    chk("busy_low_at_done", 32'(busy_o), 0);
    chk("cs_high_at_done", 32'(cs_o), 1);
    chk("done_count", done_cnt, 1);
    chk("scl_rises", rise_cnt, 8 * (1 + len));
    chk("rx_pulses", rx_cnt, len);
    chk("mosi_bits_left", exp_bits.size(), 0);
    chk("rx_bytes_left", exp_rx.size(), 0);
    if (len == 0) chk("tx_ready_len0", ready_cnt, 0);
    if (chain) begin
      prep(caddr, 0, 8'h00, 8'h00);
      addr_i  = caddr;
      len_i   = '0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("chained_start_accepted", 32'(busy_o), 1);
    end else begin
      step();
    end
    chk("done_single_cycle", 32'(done_o), 0);
  endtask

  // Compare process: slave model, serial-bit scoreboard and per-cycle counters.
  initial begin : monitor
    logic [31:0] expv;
    logic [7:0]  tmp;
    logic [7:0]  slave_idx;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        if (!cs_o && prev_cs) begin
          if (seen_cs_low) chk("cs_deselect_min", 32'(cs_high_run >= CLK_DIV), 1);
          seen_cs_low = 1'b1;
          cs_high_run = 0;
          slave_bits  = 0;
          fall_cnt    = 0;
          miso_i      = 1'b0;
        end
        if (cs_o) cs_high_run++;
        if (scl_o && !prev_scl) begin
          chk("cs_low_at_rise", 32'(cs_o), 0);
          if (exp_bits.size() > 0) expv = 32'(exp_bits.pop_front());
          else expv = 'x;
          chk("mosi_at_rise", 32'(mosi_o), expv);
          rise_cnt++;
          slave_sh = {slave_sh[6:0], mosi_o};
          slave_bits++;
          if (slave_bits % 8 == 0) begin
            if (slave_bits == 8) slave_addr = slave_sh;
            else begin
              slave_idx = slave_addr + 8'(slave_bits / 8 - 2);
              slave_mem[slave_idx] = slave_sh;
            end
          end
        end
        if (!scl_o && prev_scl) begin
          fall_cnt++;
          tmp = miso_pat << (fall_cnt % 8);
          miso_i = (fall_cnt >= 8) ? tmp[7] : 1'b0;
        end
        if (rx_valid_o) begin
          if (exp_rx.size() > 0) expv = 32'(exp_rx.pop_front());
          else expv = 'x;
          chk("rx_data", 32'(rx_data_o), expv);
          last_rx = rx_data_o;
          rx_cnt++;
        end
        if (tx_ready_o) ready_cnt++;
        if (busy_o) busy_cnt++;
        if (done_o) done_cnt++;
      end
      prev_scl = scl_o;
      prev_cs  = cs_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int bad;
    repeat (3) step();
    chk("rst_cs", 32'(cs_o), 1);
    chk("rst_scl", 32'(scl_o), 0);
    chk("rst_mosi", 32'(mosi_o), 0);
    chk("rst_tx_ready", 32'(tx_ready_o), 0);
    chk("rst_rx_data", 32'(rx_data_o), 0);
    chk("rst_rx_valid", 32'(rx_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    reset_n_i = 1'b1;
    mon_en    = 1'b1;
    repeat (2) step();

    // 1: addr 0x01, one data byte 0xA5
    miso_pat = 8'h96;
    begin_txn(8'h01, 1, 8'hA5, 8'h00);
    feed_byte(8'hA5, 0);
    end_txn(1, 1'b0, 8'h00);
    chk("t1_rises_16", rise_cnt, 16);
    chk("t1_slave_mem1", 32'(slave_mem[1]), 'hA5);

    // 2: two data bytes, second held off 40 cycles
    begin_txn(8'h10, 2, 8'h81, 8'h7E);
    feed_byte(8'h81, 0);
    feed_byte(8'h7E, 40);
    end_txn(2, 1'b0, 8'h00);
    chk("t2_rises_24", rise_cnt, 24);
    chk("t2_slave_mem10", 32'(slave_mem[8'h10]), 'h81);
    chk("t2_slave_mem11", 32'(slave_mem[8'h11]), 'h7E);

    // 3: address only; busy spans CS setup + 8 bits + CS hold + deselect
    begin_txn(8'h00, 0, 8'h00, 8'h00);
    end_txn(0, 1'b0, 8'h00);
    chk("t3_busy_cycles", busy_cnt, 76);
    chk("t3_no_rx", rx_cnt, 0);

    // 4: slave returns 0x3C in every data slot
    miso_pat = 8'h3C;
    begin_txn(8'h05, 2, 8'h11, 8'h22);
    n = 0;
    while (tx_ready_o !== 1'b1 && n < 2000) begin step(); n++; end
    chk("t4_no_rx_in_addr", rx_cnt, 0);
    feed_byte(8'h11, 0);
    feed_byte(8'h22, 0);
    end_txn(2, 1'b0, 8'h00);
    chk("t4_last_rx", 32'(last_rx), 'h3C);

    // 5: reset during bit 3 (high phase) of a data byte, then a clean transaction
    miso_pat = 8'h96;
    begin_txn(8'h40, 1, 8'hC8, 8'h00);
    feed_byte(8'hC8, 0);
    n = 0;
    while (rise_cnt < 13 && n < 2000) begin step(); n++; end
    chk("t5_reached_bit3", rise_cnt, 13);
    #2;
    reset_n_i = 1'b0;
    mon_en    = 1'b0;
    #1;
    chk("t5_rst_cs", 32'(cs_o), 1);
    chk("t5_rst_scl", 32'(scl_o), 0);
    chk("t5_rst_mosi", 32'(mosi_o), 0);
    chk("t5_rst_busy", 32'(busy_o), 0);
    repeat (3) step();
    reset_n_i   = 1'b1;
    seen_cs_low = 1'b0;
    step();
    mon_en = 1'b1;
    begin_txn(8'h00, 1, 8'h5A, 8'h00);
    feed_byte(8'h5A, 0);
    end_txn(1, 1'b0, 8'h00);
    chk("t5_slave_mem0", 32'(slave_mem[0]), 'h5A);

    // 6: starts during SHIFT and CS_IDLE are ignored; start right after done is taken
    begin_txn(8'h22, 0, 8'h00, 8'h00);
    n = 0;
    while (rise_cnt < 3 && n < 2000) begin step(); n++; end
    addr_i  = 8'h99;
    len_i   = LEN_W'(3);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (!(cs_o === 1'b1 && busy_o === 1'b1) && n < 2000) begin step(); n++; end
    chk("t6_in_cs_idle", 32'(cs_o && busy_o), 1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    end_txn(0, 1'b0, 8'h00);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy_o !== 1'b0 || cs_o !== 1'b1) bad++;
    end
    chk("t6_starts_ignored", bad, 0);
    begin_txn(8'h33, 0, 8'h00, 8'h00);
    end_txn(0, 1'b1, 8'h44);
    end_txn(0, 1'b0, 8'h00);

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
